// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake, the instruction-memory write port and
//   the load status lines of the instruction-memory loader.
//   master : the side that drives the byte stream and restart and observes
//            the write port and status (a test bench or a host bridge).
//   slave  : the loader itself.
//   Signals:
//     rx_valid / rx_data / rx_ready : byte stream, transfer when valid & ready
//     restart                       : one-cycle request to start a new load
//     im_we / im_addr / im_wd       : instruction-memory word write port
//     cpu_run                       : high when the program is loaded and valid
//     load_err                      : high when the last load was rejected
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        restart;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wd;
    logic        cpu_run;
    logic        load_err;

    modport master (
        output rx_valid, rx_data, restart,
        input  rx_ready, im_we, im_addr, im_wd, cpu_run, load_err
    );

    modport slave (
        input  rx_valid, rx_data, restart,
        output rx_ready, im_we, im_addr, im_wd, cpu_run, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program as a byte stream and writes it into instruction memory.
//   Stream: N (16 bit, MSB first), N big-endian 32-bit words, then one
//   checksum byte equal to the XOR of all payload bytes. The core is released
//   (cpu_run) only after a matching checksum; any malformed load ends in an
//   error state that only restart or reset leaves.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : imem_loader_if.slave (byte stream, write port, status)
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'd0,
    parameter logic [15:0] MAX_WORDS = 16'd64
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CKSUM,
        DONE,
        ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_live;     // low until the first edge after reset release
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [23:0] r_asm;      // leading three bytes; the 4th completes the word
    logic [1:0]  r_bcnt;
    logic [15:0] r_wcnt;
    logic [15:0] r_n;
    logic [7:0]  r_ck;

    logic        w_ready;
    logic        w_xfer;
    logic        w_word_done;
    logic [15:0] w_n;
    logic [15:0] w_wcnt_inc;
    logic [31:0] w_word;

    // No byte is taken while a write is on the bus.
    assign w_ready     = r_live && !r_we &&
                         (r_state == HDR_HI || r_state == HDR_LO ||
                          r_state == DATA   || r_state == CKSUM);
    assign w_xfer      = bus.rx_valid && w_ready;
    assign w_n         = {r_n[15:8], bus.rx_data};
    assign w_wcnt_inc  = r_wcnt + 16'd1;
    assign w_word      = {r_asm, bus.rx_data};
    assign w_word_done = (r_state == DATA) && w_xfer && (r_bcnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.restart) begin
            w_next = HDR_HI;
        end else if (w_xfer) begin
            case (r_state)
                HDR_HI: w_next = HDR_LO;
                HDR_LO: begin
                    if (w_n == 16'd0) begin
                        w_next = CKSUM;
                    end else if (w_n > MAX_WORDS) begin
                        w_next = ERROR;
                    end else begin
                        w_next = DATA;
                    end
                end
                DATA: begin
                    if (w_word_done && (w_wcnt_inc == r_n)) begin
                        w_next = CKSUM;
                    end
                end
                CKSUM: begin
                    if (bus.rx_data == r_ck) begin
                        w_next = DONE;
                    end else begin
                        w_next = ERROR;
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= 32'd0;
            r_wd   <= 32'd0;
            r_asm  <= 24'd0;
            r_bcnt <= 2'd0;
            r_wcnt <= 16'd0;
            r_n    <= 16'd0;
            r_ck   <= 8'd0;
        end else begin
            r_live <= 1'b1;
            r_we   <= 1'b0;
            // restart wins over a byte on the same edge; that byte is dropped.
            if (bus.restart) begin
                r_bcnt <= 2'd0;
                r_wcnt <= 16'd0;
                r_ck   <= 8'd0;
            end else if (w_xfer) begin
                case (r_state)
                    HDR_HI: r_n[15:8] <= bus.rx_data;
                    HDR_LO: r_n <= w_n;
                    DATA: begin
                        r_asm  <= w_word[23:0];
                        r_bcnt <= r_bcnt + 2'd1;
                        r_ck   <= r_ck ^ bus.rx_data;
                        if (w_word_done) begin
                            r_we   <= 1'b1;
                            // Wraps modulo 2^32 by width.
                            r_addr <= ADDR_BASE + {16'd0, r_wcnt};
                            r_wd   <= w_word;
                            r_wcnt <= w_wcnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready = w_ready;
    assign bus.im_we    = r_we;
    assign bus.im_addr  = r_addr;
    assign bus.im_wd    = r_wd;
    assign bus.cpu_run  = (r_state == DONE);
    assign bus.load_err = (r_state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [63:0] exp_q[$];

    imem_loader_if bus();

    imem_loader #(.ADDR_BASE(32'd0), .MAX_WORDS(16'd64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        if (gap != 0) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        guard = 0;
        while (bus.rx_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL rx_ready_timeout byte %0h got no ready want ready", b);
        end else begin
            tick();
        end
    endtask

    // Bytes are sent from the most significant used byte of v downwards.
    task automatic send_bytes(input logic [127:0] v, input int n, input int gap);
        logic [127:0] t;
        t = v;
        for (int i = 0; i < n; i++) begin
            send_byte(t[8*(n-1-i) +: 8], gap);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.rx_valid = 1'b0;
        bus.restart  = 1'b1;
        tick();
        bus.restart  = 1'b0;
    endtask

    task automatic push_nominal();
        exp_q.push_back({32'd0, 32'h2008_0005});
        exp_q.push_back({32'd1, 32'h8C01_0004});
    endtask

    // Scoreboard monitor: compares every write seen on the bus.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.im_we === 1'b1) begin
                check("rx_ready_in_we_cycle", {63'd0, bus.rx_ready}, 64'd0);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write got addr=%0h wd=%0h want none", bus.im_addr, bus.im_wd);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.im_addr, bus.im_wd} !== e) begin
                        n_bad++;
                        $display("FAIL write got addr=%0h wd=%0h want addr=%0h wd=%0h",
                                 bus.im_addr, bus.im_wd, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.restart  = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {bus.im_we, bus.cpu_run, bus.load_err, bus.rx_ready, bus.im_addr},
              64'd0);
        check("reset_wd", {32'd0, bus.im_wd}, 64'd0);
        reset = 1'b0;
        check("ready_before_first_edge", {63'd0, bus.rx_ready}, 64'd0);
        tick();
        check("ready_after_first_edge", {63'd0, bus.rx_ready}, 64'd1);

        // Nominal load, rx_valid held high throughout.
        push_nominal();
        send_bytes(88'h00_02_20080005_8C010004_A4, 11, 0);
        check("nominal_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b100);
        pulse_restart();
        check("restart_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b001);

        // Bad checksum.
        push_nominal();
        send_bytes(88'h00_02_20080005_8C010004_A5, 11, 0);
        check("badck_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b010);
        pulse_restart();

        // Length above the limit.
        send_bytes(16'h0041, 2, 0);
        tick();
        check("toolong_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b010);
        pulse_restart();

        // Empty program.
        send_bytes(24'h00_00_00, 3, 0);
        check("empty_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b100);
        pulse_restart();

        // Nominal load with idle gaps.
        push_nominal();
        send_bytes(88'h00_02_20080005_8C010004_A4, 11, 1);
        check("gaps_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b100);
        pulse_restart();

        // Restart after byte 2 of word 1, then a one-word load.
        exp_q.push_back({32'd0, 32'h1122_3344});
        send_bytes(48'h0002_11223344, 6, 0);
        check("write_latency", {63'd0, bus.im_we}, 64'd1);
        send_bytes(16'h5566, 2, 0);
        pulse_restart();
        check("restart_mid_data", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b001);
        exp_q.push_back({32'd0, 32'hDEAD_BEEF});
        send_bytes(56'h0001_DEADBEEF_22, 7, 0);
        check("one_word_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b100);
        pulse_restart();

        // Asynchronous reset while a write is on the bus.
        send_bytes(48'h0002_11223344, 6, 0);
        check("we_before_reset", {63'd0, bus.im_we}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {bus.im_we, bus.cpu_run, bus.load_err, bus.rx_ready, bus.im_wd}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("ready_after_reset", {63'd0, bus.rx_ready}, 64'd1);
        push_nominal();
        send_bytes(88'h00_02_20080005_8C010004_A4, 11, 0);
        check("post_reset_status", {61'd0, bus.cpu_run, bus.load_err, bus.rx_ready}, 64'b100);

        repeat (3) tick();
        check("pending_writes", {32'd0, exp_q.size()}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_BASE, default 32'd0: word address of the first word written into instruction memory.
REQ-002 Parameter MAX_WORDS, default 16'd64: largest accepted program length in words.
REQ-003 Port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port rx_valid, input, 1: rx_data holds a byte.
REQ-006 Port rx_data, input, 8: stream byte.
REQ-007 Port rx_ready, output, 1: the loader can accept a byte.
REQ-008 Port restart, input, 1: one-cycle request to start a new load.
REQ-009 Port im_we, output, 1: instruction-memory write strobe.
REQ-010 Port im_addr, output, 32: instruction-memory word address.
REQ-011 Port im_wd, output, 32: instruction-memory write data.
REQ-012 Port cpu_run, output, 1: releases the processor; low means the core and PC are held.
REQ-013 Port load_err, output, 1: the last load was rejected.

Function
REQ-014 A byte transfers on a rising edge only when rx_valid and rx_ready are both high; no other byte is consumed.
REQ-015 Stream format, in order:
- N[15:8], then N[7:0].
- N words, each 4 bytes big-endian (MSB first).
- One checksum byte, equal to the XOR of all 4N payload bytes.
REQ-016 FSM states: HDR_HI, HDR_LO, DATA, CKSUM, DONE, ERROR.
REQ-017 Transitions:
- HDR_HI -> HDR_LO on a transfer.
- HDR_LO -> DATA on a transfer with 1 <= N <= MAX_WORDS.
- HDR_LO -> CKSUM when N = 0.
- HDR_LO -> ERROR when N > MAX_WORDS.
REQ-018 DATA state:
- A 2-bit byte counter shifts bytes into a 32-bit assembly register.
- A 16-bit word counter counts completed words.
- After the 4th byte of word k, the block SHALL assert im_we for exactly one cycle, with im_addr = ADDR_BASE + k and im_wd = the assembled word.
- DATA -> CKSUM after word N-1 is written.
REQ-019 The write latency SHALL be 1 cycle: im_we is high in the cycle immediately after the 4th byte's transfer edge.
REQ-020 im_we SHALL be low in every other cycle.
REQ-021 im_addr and im_wd SHALL hold their last written values while im_we is low.
REQ-022 im_addr SHALL be computed modulo 2^32; it wraps silently and raises no error.
REQ-023 Checksum:
- The running XOR clears on entry to HDR_HI.
- Every DATA byte updates it.
- CKSUM -> DONE on a matching byte; CKSUM -> ERROR on a mismatch.
REQ-024 rx_ready SHALL be high in HDR_HI, HDR_LO, DATA and CKSUM, and low in DONE and ERROR.
REQ-025 rx_ready SHALL also be low in the im_we cycle, so no byte is taken while a write is issued.
REQ-026 cpu_run SHALL be high only in DONE.
REQ-027 load_err SHALL be high only in ERROR.
REQ-028 restart, sampled in any state, SHALL force HDR_HI on the next edge.
- It drops cpu_run and load_err.
- It clears the byte counter, the word counter and the checksum.
- restart takes priority over a byte transfer on the same edge; that byte is discarded but still counts as accepted.
REQ-029 A write already issued (im_we high) when restart is sampled SHALL complete; no further writes follow it.
REQ-030 DONE and ERROR SHALL be exited only by restart or reset.
REQ-031 Bytes presented while rx_ready is low SHALL be ignored.

Reset
REQ-032 reset SHALL put the FSM in HDR_HI.
REQ-033 reset SHALL clear all counters, the checksum and the assembly register.
REQ-034 Output values while reset is high: im_we = 0, im_addr = 0, im_wd = 0, cpu_run = 0, load_err = 0, rx_ready = 0.
REQ-035 rx_ready SHALL become 1 on the first clock edge after reset deasserts.
REQ-036 Reset asserted in mid-load SHALL abandon the load immediately and generate no further im_we; memory contents already written are not undone.

Verification
REQ-037 Bench scenario, nominal load:
- Stimulus: bytes 00 02 | 20 08 00 05 | 8C 01 00 04 | cksum (AC 09 00 01 XOR).
- Response: writes (0, 0x20080005) then (1, 0x8C010004); cpu_run = 1; load_err = 0.
REQ-038 Bench scenario, bad checksum:
- Stimulus: same stream with the checksum byte XOR 0x01.
- Response: both writes occur; then load_err = 1, cpu_run = 0, rx_ready = 0.
REQ-039 Bench scenario, length limits:
- Stimulus: N = 0x0041 with MAX_WORDS = 64.
- Response: ERROR state with no im_we.
- Stimulus: N = 0, then checksum 00.
- Response: DONE state with no writes.
REQ-040 Bench scenario, back-pressure and gaps:
- Stimulus: rx_valid held high continuously, then random idle cycles.
- Response: rx_ready is low in each im_we cycle; no byte is lost or duplicated; write data is identical to the nominal case.
REQ-041 Bench scenario, restart mid-DATA:
- Stimulus: restart after byte 2 of word 1, then a full 1-word load of 0xDEADBEEF.
- Response: single write (0, 0xDEADBEEF); cpu_run = 1.
REQ-042 Bench scenario, reset mid-load:
- Stimulus: reset asserted asynchronously between clock edges during DATA.
- Response: im_we and cpu_run go low immediately; after release the FSM is in HDR_HI and accepts a fresh load.
